tsc_multi: RTL and testbench
============================

TSC_MULTI -- requirements
Module: tsc_multi

Interface
REQ-001 SHALL have parameter DATA_W, default 8, bits per channel sample.
REQ-002 SHALL have parameter DEPTH, default 32, frame length in samples (power of 2, >=4).
REQ-003 SHALL have parameter NUM_CH, default 2, channels per sample word.
REQ-004 SHALL have parameter PRE_TRIG, default 8, pre-trigger samples (0..DEPTH-1).
REQ-005 SHALL have parameter TS_W, default 32, timestamp width.
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-008 SHALL have port start  in  1  one-cycle arm request.
REQ-009 SHALL have port sbf  in  1  one-cycle send-buffer request.
REQ-010 SHALL have port trig_mode  in  2  00 rising, 01 falling, 10 either, 11 force.
REQ-011 SHALL have port trig_ch  in  clog2(NUM_CH) (min 1)  trigger channel select.
REQ-012 SHALL have port trig_level  in  DATA_W  unsigned threshold.
REQ-013 SHALL have port s_valid  in  1  sample strobe.
REQ-014 SHALL have port s_data  in  NUM_CH*DATA_W  samples, ch0 in LSBs.
REQ-015 SHALL have port state_out  out  3  current state code.
REQ-016 SHALL have port trd  out  1  frame captured, awaiting sbf.
REQ-017 SHALL have port sd  out  1  serial data.
REQ-018 SHALL have port cd  out  1  serial clock strobe; sd valid while cd=1.
REQ-019 SHALL have port dropped  out  1  sticky: sample arrived in DONE/SEND.

Function
REQ-020 SHALL use states IDLE=0, FILL=1, ARMED=2, POST=3, DONE=4, SEND=5.
REQ-021 SHALL run free TS_W-bit timestamp, +1 every cycle, wrapping to 0.
REQ-022 SHALL, on start in IDLE or DONE, latch trig_mode/trig_ch/trig_level, clear wr_ptr, fill count, trd, dropped; go FILL (ARMED if PRE_TRIG=0).
REQ-023 SHALL ignore start in FILL, ARMED, POST, SEND.
REQ-024 SHALL, in FILL/ARMED/POST, write each s_valid word at wr_ptr, wr_ptr +1 mod DEPTH; prev_sample of latched channel updated per write.
REQ-025 SHALL leave FILL for ARMED on the cycle after the PRE_TRIG-th write.
REQ-026 SHALL trigger in ARMED on a valid sample: rising prev<level and cur>=level; falling prev>=level and cur<level; either = both; force = first ARMED sample.
REQ-027 SHALL write triggering sample, latch timestamp and trig_idx=its address, go POST.
REQ-028 SHALL frame-start = (trig_idx-PRE_TRIG) mod DEPTH; frame = DEPTH contiguous words from there.
REQ-029 SHALL go DONE the cycle after the (DEPTH-PRE_TRIG-1)-th POST write (immediately if that count is 0); trd=1 in DONE.
REQ-030 SHALL ignore s_valid in IDLE; in DONE/SEND discard it and set dropped.
REQ-031 SHALL ignore sbf outside DONE; sbf in DONE clears trd, enters SEND.
REQ-032 SHALL serialise MSB-first: latched timestamp, then DEPTH words from frame-start, each NUM_CH*DATA_W bits.
REQ-033 SHALL spend 2 cycles per bit: sd set with cd=0, then cd=1 with sd held.
REQ-034 SHALL return to IDLE after last bit with sd=0, cd=0; SEND length 2*(TS_W+DEPTH*NUM_CH*DATA_W) cycles.
REQ-035 SHALL keep sd=0, cd=0 outside SEND.
REQ-036 SHALL take start over s_valid when both arrive in DONE (rearm, no dropped set).

Reset
REQ-037 SHALL, on reset=0 at any time, asynchronously force IDLE, state_out=0, trd=0, sd=0, cd=0, dropped=0, timestamp=0, pointers/counters/prev_sample=0.
REQ-038 SHALL resume only on first rising clk edge after reset=1; buffer contents undefined.

Verification (defaults)
REQ-039 SHALL cover: reset=0 mid-SEND -> state_out=0, sd=cd=trd=0 same cycle, no further cd.
REQ-040 SHALL cover: ch0 ramp 0,1,2.. every cycle, level=100, rising, start -> trigger on 100, trd=1 after 23 more samples, frame ch0 = 92..123.
REQ-041 SHALL cover: ch1 ramp down from 255, level=50, trig_ch=1, falling -> trigger on 49, frame ch1 = 57..26.
REQ-042 SHALL cover: sbf in DONE -> 544 cd pulses over 1088 cycles, first 32 bits = latched timestamp, then IDLE.
REQ-043 SHALL cover: start in POST and sbf in ARMED ignored; s_valid in DONE -> dropped=1 until next start.
REQ-044 SHALL cover: force mode, PRE_TRIG=8 -> trigger on 9th sample after start, frame = samples 1..32.

Source files
------------

// File: rtl/tsc_multi.sv
// ---------------------------------------------------------------------------
// tsc_multi -- multi-channel triggered sample capture with serial readout.
//
// Arms on `start`. Keeps PRE_TRIG samples of history, waits for a trigger on
// one selected channel (rising, falling, either edge, or forced), then records
// the remaining post-trigger samples so that the buffer holds one contiguous
// frame of DEPTH words. The frame is sent on request (`sbf`), MSB-first, as
// the trigger timestamp followed by the DEPTH words. Each bit takes two
// cycles: first cd=0 while sd is set up, then cd=1 with sd held.
//
// Ports
//   clk         sole clock, rising edge
//   reset       asynchronous, active-low reset
//   start       one-cycle arm request (accepted in IDLE and DONE only)
//   sbf         one-cycle send-buffer request (accepted in DONE only)
//   trig_mode   00 rising, 01 falling, 10 either, 11 force
//   trig_ch     trigger channel select
//   trig_level  unsigned trigger threshold
//   s_valid     sample strobe
//   s_data      NUM_CH samples, channel 0 in the LSBs
//   state_out   current state code (IDLE=0 .. SEND=5)
//   trd         frame captured, waiting for sbf
//   sd          serial data
//   cd          serial clock strobe, sd valid while cd=1
//   dropped     sticky: a sample arrived while in DONE or SEND
// ---------------------------------------------------------------------------
module tsc_multi #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 32,
  parameter int NUM_CH   = 2,
  parameter int PRE_TRIG = 8,
  parameter int TS_W     = 32
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic                                        sbf,
  input  logic [1:0]                                  trig_mode,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] trig_ch,
  input  logic [DATA_W-1:0]                           trig_level,
  input  logic                                        s_valid,
  input  logic [NUM_CH*DATA_W-1:0]                    s_data,
  output logic [2:0]                                  state_out,
  output logic                                        trd,
  output logic                                        sd,
  output logic                                        cd,
  output logic                                        dropped
);

  localparam int WW     = NUM_CH * DATA_W;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int TCH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int POST_N = DEPTH - PRE_TRIG - 1;
  localparam int BW     = $clog2((TS_W > WW) ? TS_W : WW) + 1;

  // Count values that mark the last fill write and the last post write.
  localparam logic [CW-1:0] FILL_LAST = CW'((PRE_TRIG > 0) ? PRE_TRIG - 1 : 0);
  localparam logic [CW-1:0] POST_LAST = CW'((POST_N > 0) ? POST_N - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4,
    ST_SEND  = 3'd5
  } state_t;

  // With no pre-trigger history there is nothing to fill.
  localparam state_t ARM_ST = (PRE_TRIG == 0) ? ST_ARMED : ST_FILL;

  state_t state_reg, state_next;

  logic [TS_W-1:0]   ts_reg;
  logic [1:0]        mode_reg;
  logic [TCH_W-1:0]  ch_reg;
  logic [DATA_W-1:0] level_reg;
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     trig_idx_reg;
  logic [AW-1:0]     rd_addr_reg;
  logic [CW-1:0]     cnt_reg;
  logic [DATA_W-1:0] prev_reg;
  logic [TS_W-1:0]   ts_lat_reg;
  logic [TS_W-1:0]   ts_sh_reg;
  logic [WW-1:0]     word_sh_reg;
  logic [WW-1:0]     rd_data_reg;
  logic              ph_reg;
  logic              in_data_reg;
  logic [BW-1:0]     bit_cnt_reg;
  logic [AW-1:0]     word_cnt_reg;
  logic              dropped_reg;

  logic [WW-1:0]     mem [DEPTH];

  // ---------------------------------------------------------------------
  // Channel split and trigger detection
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] ch_samples [NUM_CH];
  logic [DATA_W-1:0] cur_sample;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_samples[gi] = s_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Loop-based select keeps an out-of-range channel number harmless.
  always_comb begin
    cur_sample = ch_samples[0];
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_reg == TCH_W'(i)) cur_sample = ch_samples[i];
    end
  end

  logic prev_above, cur_above, trig_hit;

  always_comb begin
    prev_above = (prev_reg >= level_reg);
    cur_above  = (cur_sample >= level_reg);
    trig_hit   = 1'b0;
    case (mode_reg)
      2'b00:   trig_hit = !prev_above && cur_above;
      2'b01:   trig_hit = prev_above && !cur_above;
      2'b10:   trig_hit = prev_above != cur_above;
      default: trig_hit = 1'b1;
    endcase
  end

  logic capturing, wr_en, arm_req;
  logic ts_last_bit, word_last_bit, send_last;
  logic [AW-1:0] frame_start;

  assign capturing = (state_reg == ST_FILL) || (state_reg == ST_ARMED) ||
                     (state_reg == ST_POST);
  assign wr_en     = s_valid && capturing;
  assign arm_req   = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

  // Oldest word of the frame; wraps naturally in AW bits.
  assign frame_start = trig_idx_reg - AW'(PRE_TRIG);

  assign ts_last_bit   = !in_data_reg && (bit_cnt_reg == BW'(TS_W - 1));
  assign word_last_bit = in_data_reg && (bit_cnt_reg == BW'(WW - 1));
  assign send_last     = ph_reg && word_last_bit && (word_cnt_reg == AW'(DEPTH - 1));

  // ---------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ARM_ST;
      end
      ST_FILL: begin
        if (s_valid && (cnt_reg == FILL_LAST)) state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (s_valid && trig_hit) state_next = (POST_N == 0) ? ST_DONE : ST_POST;
      end
      ST_POST: begin
        if (s_valid && (cnt_reg == POST_LAST)) state_next = ST_DONE;
      end
      ST_DONE: begin
        // A re-arm wins over a send request arriving in the same cycle.
        if (start)    state_next = ARM_ST;
        else if (sbf) state_next = ST_SEND;
      end
      ST_SEND: begin
        if (send_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath: timestamp, capture bookkeeping, serialiser
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_reg       <= '0;
      mode_reg     <= '0;
      ch_reg       <= '0;
      level_reg    <= '0;
      wr_ptr_reg   <= '0;
      trig_idx_reg <= '0;
      rd_addr_reg  <= '0;
      cnt_reg      <= '0;
      prev_reg     <= '0;
      ts_lat_reg   <= '0;
      ts_sh_reg    <= '0;
      word_sh_reg  <= '0;
      ph_reg       <= 1'b0;
      in_data_reg  <= 1'b0;
      bit_cnt_reg  <= '0;
      word_cnt_reg <= '0;
      dropped_reg  <= 1'b0;
    end else begin
      ts_reg <= ts_reg + TS_W'(1);

      if (arm_req) begin
        // Trigger configuration is frozen for the whole capture.
        mode_reg    <= trig_mode;
        ch_reg      <= trig_ch;
        level_reg   <= trig_level;
        wr_ptr_reg  <= '0;
        cnt_reg     <= '0;
        dropped_reg <= 1'b0;
      end else begin
        if (wr_en) begin
          wr_ptr_reg <= wr_ptr_reg + AW'(1);
          prev_reg   <= cur_sample;
        end

        case (state_reg)
          ST_FILL: begin
            if (s_valid) cnt_reg <= (cnt_reg == FILL_LAST) ? '0 : cnt_reg + CW'(1);
          end
          ST_ARMED: begin
            if (s_valid && trig_hit) begin
              ts_lat_reg   <= ts_reg;
              trig_idx_reg <= wr_ptr_reg;
              cnt_reg      <= '0;
            end
          end
          ST_POST: begin
            if (s_valid) cnt_reg <= cnt_reg + CW'(1);
          end
          ST_DONE: begin
            if (s_valid) dropped_reg <= 1'b1;
            if (sbf) begin
              ph_reg       <= 1'b0;
              in_data_reg  <= 1'b0;
              bit_cnt_reg  <= '0;
              word_cnt_reg <= '0;
              ts_sh_reg    <= ts_lat_reg;
              rd_addr_reg  <= frame_start;
            end
          end
          ST_SEND: begin
            if (s_valid) dropped_reg <= 1'b1;
            ph_reg <= ~ph_reg;
            // Advance the bit at the end of its cd=1 cycle. The next word
            // is already in rd_data_reg because its address was issued at
            // least two cycles earlier.
            if (ph_reg) begin
              if (!in_data_reg) begin
                if (ts_last_bit) begin
                  in_data_reg <= 1'b1;
                  bit_cnt_reg <= '0;
                  word_sh_reg <= rd_data_reg;
                  rd_addr_reg <= rd_addr_reg + AW'(1);
                end else begin
                  ts_sh_reg   <= ts_sh_reg << 1;
                  bit_cnt_reg <= bit_cnt_reg + BW'(1);
                end
              end else if (word_last_bit) begin
                bit_cnt_reg  <= '0;
                word_cnt_reg <= word_cnt_reg + AW'(1);
                word_sh_reg  <= rd_data_reg;
                rd_addr_reg  <= rd_addr_reg + AW'(1);
              end else begin
                word_sh_reg <= word_sh_reg << 1;
                bit_cnt_reg <= bit_cnt_reg + BW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Sample buffer: plain array with registered read, contents not reset
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= s_data;
    rd_data_reg <= mem[rd_addr_reg];
  end

  // ---------------------------------------------------------------------
  // Outputs decode from registered state so reset clears them at once
  // ---------------------------------------------------------------------
  assign state_out = state_reg;
  assign trd       = (state_reg == ST_DONE);
  assign cd        = (state_reg == ST_SEND) && ph_reg;
  assign sd        = (state_reg == ST_SEND) &&
                     (in_data_reg ? word_sh_reg[WW-1] : ts_sh_reg[TS_W-1]);
  assign dropped   = dropped_reg;

endmodule

// File: tb/tb_tsc_multi.sv
module tb_tsc_multi;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 32;
  localparam int NUM_CH   = 2;
  localparam int PRE_TRIG = 8;
  localparam int TS_W     = 32;
  localparam int WW       = NUM_CH * DATA_W;
  localparam int POST_N   = DEPTH - PRE_TRIG - 1;
  localparam int NBITS    = TS_W + DEPTH * WW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          sbf = 1'b0;
  logic [1:0]    trig_mode = '0;
  logic          trig_ch = 1'b0;
  logic [7:0]    trig_level = '0;
  logic          s_valid = 1'b0;
  logic [15:0]   s_data = '0;
  logic [2:0]    state_out;
  logic          trd, sd, cd, dropped;

  int checks = 0;
  int fails  = 0;
  int edges  = 0;

  logic [31:0] exp_q[$];       // scoreboard: expected serial fields
  logic [31:0] frame_exp[$];   // expected frame of the latest capture

  tsc_multi #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH),
    .PRE_TRIG(PRE_TRIG), .TS_W(TS_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .sbf(sbf),
    .trig_mode(trig_mode), .trig_ch(trig_ch), .trig_level(trig_level),
    .s_valid(s_valid), .s_data(s_data), .state_out(state_out),
    .trd(trd), .sd(sd), .cd(cd), .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock; edges counts rising edges seen out of reset, which is the
  // timestamp value the DUT holds just before the next edge.
  task automatic tick();
    @(posedge clk);
    if (reset) edges++;
    #1;
  endtask

  function automatic int chan(input logic [15:0] w, input int c);
    return int'((w >> (c * DATA_W)) & 16'h00FF);
  endfunction

  // kind 0: random; 1: ch0 ramps up 0,1,2..; 2: ch1 ramps down 255,254..
  function automatic logic [15:0] gen(input int kind, input int n);
    logic [15:0] w;
    w = 16'($urandom);
    if (kind == 1)      w[7:0]  = 8'(n);
    else if (kind == 2) w[15:8] = 8'(255 - n);
    return w;
  endfunction

  // Arm, feed samples, and predict trigger point / frame from the sample
  // history. Leaves the expected frame in frame_exp.
  task automatic capture(input int mode, input int ch, input int lvl, input int kind,
                         input int vpct, input bit arm_valid, input bit inject,
                         output bit ok);
    logic [15:0] hist[$];
    int hts[$];
    int n, trig, guard, cur, prv, exp_st;
    bit last, hit, sbf_done, start_done;
    logic [15:0] w;

    trig_mode  = 2'(mode);
    trig_ch    = ch[0];
    trig_level = 8'(lvl);
    start      = 1'b1;
    s_valid    = arm_valid;
    s_data     = 16'($urandom);
    tick();
    start   = 1'b0;
    s_valid = 1'b0;
    chk("arm_state", state_out, 1);
    chk("arm_dropped", dropped, 0);
    chk("arm_trd", trd, 0);
    // The configuration must have been latched at arm time.
    trig_mode  = 2'($urandom);
    trig_ch    = 1'($urandom);
    trig_level = 8'($urandom);

    n = 0; trig = -1; last = 0; guard = 0; sbf_done = 0; start_done = 0;
    while (!last && guard < 600) begin
      guard++;
      if (inject && !sbf_done && trig < 0 && n >= PRE_TRIG) begin
        sbf = 1'b1; sbf_done = 1;
      end
      if (inject && !start_done && trig > 0 && n == trig + 2) begin
        start = 1'b1; start_done = 1;
      end
      if ($urandom_range(99) < vpct) begin
        w = gen(kind, n);
        s_valid = 1'b1;
        s_data  = w;
        hist.push_back(w);
        hts.push_back(edges);
        n++;
        if (trig < 0 && n > PRE_TRIG) begin
          cur = chan(w, ch);
          prv = chan(hist[n-2], ch);
          case (mode)
            0:       hit = (prv < lvl) && (cur >= lvl);
            1:       hit = (prv >= lvl) && (cur < lvl);
            2:       hit = ((prv < lvl) && (cur >= lvl)) || ((prv >= lvl) && (cur < lvl));
            default: hit = 1;
          endcase
          if (hit) trig = n;
        end
        if (trig > 0 && n == trig + POST_N) last = 1;
      end else begin
        s_valid = 1'b0;
        s_data  = 16'($urandom);
      end
      tick();
      s_valid = 1'b0;
      sbf     = 1'b0;
      start   = 1'b0;
      exp_st = (n < PRE_TRIG) ? 1 : (trig < 0) ? 2 : (n < trig + POST_N) ? 3 : 4;
      chk("state", state_out, exp_st);
      chk("trd", trd, exp_st == 4);
    end

    frame_exp.delete();
    if (trig < 0) begin
      chk("no_trigger_state", state_out, 2);
      ok = 0;
    end else begin
      frame_exp.push_back(32'(hts[trig-1]));
      for (int i = 0; i < DEPTH; i++) frame_exp.push_back(32'(hist[trig-1-PRE_TRIG+i]));
      ok = 1;
    end
  endtask

  // Request readout. abort_after > 0 pulls reset after that many SEND cycles.
  task automatic send(input int abort_after);
    int cyc, pulses;
    foreach (frame_exp[i]) exp_q.push_back(frame_exp[i]);
    sbf = 1'b1;
    tick();
    sbf = 1'b0;
    cyc = 0; pulses = 0;
    while (state_out == 3'd5 && cyc < 3000) begin
      if (cd) pulses++;
      cyc++;
      if (abort_after > 0 && cyc >= abort_after) break;
      tick();
    end
    if (abort_after > 0) begin
      chk("abort_pulses", pulses, abort_after / 2);
      reset = 1'b0;
      edges = 0;
      #1;
      chk("rst_state", state_out, 0);
      chk("rst_sd", sd, 0);
      chk("rst_cd", cd, 0);
      chk("rst_trd", trd, 0);
      repeat (3) tick();
      reset = 1'b1;
      pulses = 0;
      repeat (40) begin
        tick();
        if (cd) pulses++;
      end
      chk("post_rst_cd_pulses", pulses, 0);
      chk("post_rst_state", state_out, 0);
    end else begin
      chk("send_cycles", cyc, 2 * NBITS);
      chk("send_pulses", pulses, NBITS);
      chk("send_end_state", state_out, 0);
      chk("send_end_sd", sd, 0);
      chk("send_end_cd", cd, 0);
    end
  endtask

  task automatic recover();
    reset = 1'b0;
    edges = 0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  // Monitor: rebuild serial fields on every cd strobe and compare them with
  // the scoreboard in order (timestamp first, then DEPTH words).
  initial begin
    logic [31:0] acc;
    logic [31:0] e;
    int mbits, midx;
    acc = '0; mbits = 0; midx = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        acc = '0; mbits = 0; midx = 0;
        exp_q.delete();
      end else if (cd === 1'b1) begin
        acc = {acc[30:0], sd};
        mbits++;
        if (mbits == ((midx == 0) ? TS_W : WW)) begin
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL serial_extra: field %0d actual=%0h required=none", midx, acc);
          end else begin
            e = exp_q.pop_front();
            chk((midx == 0) ? "serial_ts" : "serial_word", acc, e);
          end
          midx  = (midx == DEPTH) ? 0 : midx + 1;
          mbits = 0;
          acc   = '0;
        end
      end
    end
  end

  initial begin
    bit ok;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", state_out, 0);
    chk("reset_trd", trd, 0);
    chk("reset_sd", sd, 0);
    chk("reset_cd", cd, 0);
    chk("reset_dropped", dropped, 0);
    reset = 1'b1;
    tick();
    chk("idle_state", state_out, 0);

    // sbf and samples in IDLE do nothing
    sbf = 1'b1;
    tick();
    sbf = 1'b0;
    chk("idle_sbf_state", state_out, 0);
    s_valid = 1'b1;
    s_data  = 16'($urandom);
    tick();
    s_valid = 1'b0;
    chk("idle_valid_dropped", dropped, 0);
    chk("idle_valid_state", state_out, 0);

    // ch0 ramp, rising through 100; sbf in ARMED and start in POST ignored
    capture(0, 0, 100, 1, 100, 0, 1, ok);
    if (ok) send(0);

    // ch1 ramp down, falling through 50; then a sample arriving in DONE
    capture(1, 1, 50, 2, 100, 0, 0, ok);
    s_valid = 1'b1;
    s_data  = 16'($urandom);
    tick();
    s_valid = 1'b0;
    chk("done_valid_dropped", dropped, 1);
    chk("done_valid_state", state_out, 4);
    chk("done_valid_trd", trd, 1);
    if (ok) send(0);
    chk("dropped_sticky", dropped, 1);

    // forced trigger with gappy strobes, left in DONE
    capture(3, int'($urandom_range(1)), int'($urandom_range(255)), 0, 60, 0, 0, ok);
    // re-arm from DONE with a simultaneous sample: start wins, no drop
    capture(2, int'($urandom_range(1)), int'($urandom_range(40, 200)), 0, 80, 1, 0, ok);
    if (ok) send(0); else recover();

    for (int it = 0; it < 6; it++) begin
      capture(int'($urandom_range(3)), int'($urandom_range(1)), int'($urandom_range(20, 230)),
              0, int'($urandom_range(50, 100)), bit'($urandom_range(1)), it == 0, ok);
      if (ok) send(0); else recover();
    end

    // reset pulled in the middle of a readout
    capture(3, 0, 0, 0, 100, 0, 0, ok);
    if (ok) send(300);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
